// File: rtl/alu_csr_unit_pkg.sv
// Shared definitions for the execute-stage ALU / CSR / breakpoint block.
//   alu_fun_e : 4-bit ALU function codes (11..15 produce 0)
//   csr_cmd_e : 2-bit CSR command (N = no access, W = write, S = set, C = clear)
//   CSR_*     : 12-bit CSR addresses implemented by alu_csr_unit
//   alu_in_t / alu_out_t : ALU operand and result bundles
package alu_csr_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SRL   = 4'd3,
        ALU_SRA   = 4'd4,
        ALU_AND   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_XOR   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_COPY1 = 4'd10
    } alu_fun_e;

    typedef enum logic [1:0] {
        CSR_N = 2'd0,
        CSR_W = 2'd1,
        CSR_S = 2'd2,
        CSR_C = 2'd3
    } csr_cmd_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_TDATA1   = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2   = 12'h7A2;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  fun;
    } alu_in_t;

    typedef struct packed {
        logic [31:0] data;
    } alu_out_t;

endpackage

// File: rtl/alu_csr_unit_alu.sv
// Purely combinational 32-bit ALU.
//   i_op1, i_op2 : operands (shifts use only i_op2[4:0])
//   i_fun        : function code (alu_fun_e); undefined codes give 0
//   o_data       : result
module alu_core
    import alu_csr_unit_pkg::*;
(
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [3:0]  i_fun,
    output logic [31:0] o_data
);

    logic [4:0] w_shamt;
    assign w_shamt = i_op2[4:0];

    always_comb begin
        o_data = '0;
        case (alu_fun_e'(i_fun))
            ALU_ADD:   o_data = i_op1 + i_op2;
            ALU_SUB:   o_data = i_op1 - i_op2;
            ALU_SLL:   o_data = i_op1 << w_shamt;
            ALU_SRL:   o_data = i_op1 >> w_shamt;
            ALU_SRA:   o_data = $unsigned($signed(i_op1) >>> w_shamt);
            ALU_AND:   o_data = i_op1 & i_op2;
            ALU_OR:    o_data = i_op1 | i_op2;
            ALU_XOR:   o_data = i_op1 ^ i_op2;
            ALU_SLT:   o_data = {31'b0, $signed(i_op1) < $signed(i_op2)};
            ALU_SLTU:  o_data = {31'b0, i_op1 < i_op2};
            ALU_COPY1: o_data = i_op1;
            default:   o_data = '0;
        endcase
    end

endmodule

// File: rtl/alu_csr_unit.sv
// Execute-stage support block: combinational ALU, machine-mode CSR file with
// cycle/instret counters and trap registers, single-address breakpoint.
//   clk, reset          : clock, synchronous active-high reset
//   alu_op1/op2/fun     : ALU inputs; alu_data is the combinational result
//   csr_cmd/addr/wdata  : CSR access; csr_rdata is the pre-write value,
//                         csr_illegal flags unknown or read-only-write access
//   retire              : instruction retired (minstret increment)
//   exception/exc_cause/exc_pc : trap capture into mcause/mepc, clears MIE
//   evec                : current mtvec
//   fetch_pc / bp_hit   : breakpoint compare against tdata2 when tdata1[0]
module alu_csr_unit
    import alu_csr_unit_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_op1,
    input  logic [31:0] alu_op2,
    input  logic [3:0]  alu_fun,
    output logic [31:0] alu_data,
    input  logic [1:0]  csr_cmd,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        retire,
    input  logic        exception,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_pc,
    output logic [31:0] evec,
    input  logic [31:0] fetch_pc,
    output logic        bp_hit
);

    alu_in_t  w_alu_in;
    alu_out_t w_alu_out;

    assign w_alu_in = '{op1: alu_op1, op2: alu_op2, fun: alu_fun};

    alu_core u_alu (
        .i_op1  (w_alu_in.op1),
        .i_op2  (w_alu_in.op2),
        .i_fun  (w_alu_in.fun),
        .o_data (w_alu_out.data)
    );

    assign alu_data = w_alu_out.data;

    logic        r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic        r_bp_en;
    logic [31:0] r_tdata2;
    logic [31:0] r_mcycle;
    logic [31:0] r_minstret;

    logic [31:0] w_rdata;
    logic        w_known;
    logic        w_ro;
    logic        w_wr;
    logic [31:0] w_new;

    always_comb begin
        w_rdata = '0;
        w_known = 1'b1;
        w_ro    = 1'b0;
        case (csr_addr)
            CSR_MSTATUS:  w_rdata = {28'b0, r_mie, 3'b0};
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = r_mepc;
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_TDATA1:   w_rdata = {31'b0, r_bp_en};
            CSR_TDATA2:   w_rdata = r_tdata2;
            CSR_MCYCLE:   w_rdata = r_mcycle;
            CSR_MINSTRET: w_rdata = r_minstret;
            CSR_CYCLE: begin
                w_rdata = r_mcycle;
                w_ro    = 1'b1;
            end
            CSR_INSTRET: begin
                w_rdata = r_minstret;
                w_ro    = 1'b1;
            end
            default:      w_known = 1'b0;
        endcase
    end

    always_comb begin
        w_new = w_rdata;
        case (csr_cmd_e'(csr_cmd))
            CSR_W:   w_new = csr_wdata;
            CSR_S:   w_new = w_rdata | csr_wdata;
            CSR_C:   w_new = w_rdata & ~csr_wdata;
            default: w_new = w_rdata;
        endcase
    end

    assign csr_illegal = !w_known || ((csr_cmd_e'(csr_cmd) != CSR_N) && w_ro);
    assign w_wr        = (csr_cmd_e'(csr_cmd) != CSR_N) && !csr_illegal;
    assign csr_rdata   = w_rdata;
    assign evec        = r_mtvec;
    assign bp_hit      = r_bp_en && (fetch_pc == r_tdata2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mie      <= 1'b0;
            r_mtvec    <= MTVEC_RESET & 32'hFFFF_FFFC;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_bp_en    <= 1'b0;
            r_tdata2   <= '0;
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            // A counter write stores the written value exactly, replacing the increment.
            r_mcycle   <= (w_wr && csr_addr == CSR_MCYCLE)   ? w_new : r_mcycle + 32'd1;
            r_minstret <= (w_wr && csr_addr == CSR_MINSTRET) ? w_new
                                                             : r_minstret + {31'b0, retire};
            if (w_wr && csr_addr == CSR_MTVEC)    r_mtvec    <= w_new & 32'hFFFF_FFFC;
            if (w_wr && csr_addr == CSR_MSCRATCH) r_mscratch <= w_new;
            if (w_wr && csr_addr == CSR_TDATA1)   r_bp_en    <= w_new[0];
            if (w_wr && csr_addr == CSR_TDATA2)   r_tdata2   <= w_new;
            // Trap capture takes priority over CSR writes to mepc/mcause/mstatus.
            if (exception) begin
                r_mepc   <= exc_pc & 32'hFFFF_FFFC;
                r_mcause <= exc_cause;
                r_mie    <= 1'b0;
            end else begin
                if (w_wr && csr_addr == CSR_MEPC)    r_mepc   <= w_new & 32'hFFFF_FFFC;
                if (w_wr && csr_addr == CSR_MCAUSE)  r_mcause <= w_new;
                if (w_wr && csr_addr == CSR_MSTATUS) r_mie    <= w_new[3];
            end
        end
    end

endmodule

// File: tb/tb_alu_csr_unit.sv
module tb_alu_csr_unit;
    import alu_csr_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_op1, alu_op2, alu_data;
    logic [3:0]  alu_fun;
    logic [1:0]  csr_cmd;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata;
    logic        csr_illegal;
    logic        retire, exception;
    logic [31:0] exc_cause, exc_pc, evec, fetch_pc;
    logic        bp_hit;

    int n_pass = 0;
    int n_total = 0;

    alu_csr_unit #(.MTVEC_RESET(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_fun(alu_fun), .alu_data(alu_data),
        .csr_cmd(csr_cmd), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .retire(retire), .exception(exception), .exc_cause(exc_cause), .exc_pc(exc_pc),
        .evec(evec), .fetch_pc(fetch_pc), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational CSR read with no write.
    task automatic rd(input logic [11:0] a);
        csr_cmd = 2'd0; csr_addr = a; csr_wdata = '0;
        #1;
    endtask

    // One-cycle CSR access, command dropped back to N afterwards.
    task automatic csr_op(input logic [1:0] c, input logic [11:0] a, input logic [31:0] d);
        csr_cmd = c; csr_addr = a; csr_wdata = d;
        tick();
        csr_cmd = 2'd0;
        #1;
    endtask

    // Reference ALU built from plain arithmetic on wide integers.
    function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [3:0] f);
        longint unsigned ua = a, ub = b;
        longint          sa = $signed(a), sb = $signed(b);
        longint unsigned p  = 64'd1 << (b % 32);
        longint unsigned r;
        case (f)
            4'd0:  r = ua + ub;
            4'd1:  r = ua + (64'h1_0000_0000 - ub);
            4'd2:  r = ua * p;
            4'd3:  r = ua / p;
            4'd4:  r = a[31] ? ~((~ua & 64'hFFFF_FFFF) / p) : ua / p;
            4'd5:  r = ua & ub;
            4'd6:  r = ua | ub;
            4'd7:  r = ua ^ ub;
            4'd8:  r = (sa < sb) ? 1 : 0;
            4'd9:  r = (ua < ub) ? 1 : 0;
            4'd10: r = ua;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    typedef struct {
        string       name;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  fun;
        logic [31:0] exp;
    } alu_vec_t;

    alu_vec_t vecs[$];

    logic [31:0] m_regs[4];
    logic [11:0] m_addr[4];
    logic [31:0] m_mask[4];

    initial begin
        vecs.push_back('{"add",   32'hFFFF_FFF0, 32'h24, 4'd0,  32'h0000_0014});
        vecs.push_back('{"sub",   32'hFFFF_FFF0, 32'h24, 4'd1,  32'hFFFF_FFCC});
        vecs.push_back('{"sll",   32'hFFFF_FFF0, 32'h24, 4'd2,  32'hFFFF_FF00});
        vecs.push_back('{"srl",   32'hFFFF_FFF0, 32'h24, 4'd3,  32'h0FFF_FFFF});
        vecs.push_back('{"sra",   32'hFFFF_FFF0, 32'h24, 4'd4,  32'hFFFF_FFFF});
        vecs.push_back('{"and",   32'hFFFF_FFF0, 32'h24, 4'd5,  32'h0000_0020});
        vecs.push_back('{"or",    32'hFFFF_FFF0, 32'h24, 4'd6,  32'hFFFF_FFF4});
        vecs.push_back('{"xor",   32'hFFFF_FFF0, 32'h24, 4'd7,  32'hFFFF_FFD4});
        vecs.push_back('{"slt",   32'hFFFF_FFF0, 32'h24, 4'd8,  32'h1});
        vecs.push_back('{"sltu",  32'hFFFF_FFF0, 32'h24, 4'd9,  32'h0});
        vecs.push_back('{"copy1", 32'hFFFF_FFF0, 32'h24, 4'd10, 32'hFFFF_FFF0});
        vecs.push_back('{"fun12", 32'hFFFF_FFF0, 32'h24, 4'd12, 32'h0});
        vecs.push_back('{"fun15", 32'h1234_5678, 32'h1,  4'd15, 32'h0});
        vecs.push_back('{"sllmask", 32'h1,       32'h21, 4'd2,  32'h2});
        vecs.push_back('{"sramask", 32'h8000_0000, 32'hFFFF_FFFF, 4'd4, 32'hFFFF_FFFF});

        m_addr = '{12'h340, 12'h341, 12'h300, 12'h7A2};
        m_mask = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0008, 32'hFFFF_FFFF};

        reset = 1'b1; alu_op1 = '0; alu_op2 = '0; alu_fun = '0;
        csr_cmd = '0; csr_addr = 12'h300; csr_wdata = '0;
        retire = 1'b0; exception = 1'b0; exc_cause = '0; exc_pc = '0; fetch_pc = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("evec_rst", evec, 32'h100);
        rd(12'h305); chk("mtvec_rst", csr_rdata, 32'h100);
        rd(12'h300); chk("mstatus_rst", csr_rdata, 32'h0);
        rd(12'h340); chk("mscratch_rst", csr_rdata, 32'h0);
        rd(12'h7A1); chk("tdata1_rst", csr_rdata, 32'h0);
        rd(12'hB00); chk("mcycle_rst", csr_rdata, 32'h0);
        chk("bp_rst", {31'b0, bp_hit}, 32'h0);

        // Idle cycles: mcycle counts edges since reset release
        repeat (5) tick();
        rd(12'hB00); chk("mcycle_idle5", csr_rdata, 32'd5);
        rd(12'hC00); chk("cycle_alias", csr_rdata, 32'd5);
        chk("cycle_read_legal", {31'b0, csr_illegal}, 32'h0);
        rd(12'hB02); chk("minstret_idle", csr_rdata, 32'd0);

        // ALU table
        foreach (vecs[i]) begin
            alu_op1 = vecs[i].op1; alu_op2 = vecs[i].op2; alu_fun = vecs[i].fun;
            #1;
            chk(vecs[i].name, alu_data, vecs[i].exp);
        end

        // ALU random vs model
        for (int i = 0; i < 300; i++) begin
            alu_op1 = $urandom; alu_op2 = (i % 3 == 0) ? $urandom_range(0, 40) : $urandom;
            alu_fun = 4'($urandom_range(0, 15));
            if (i % 7 == 0) alu_op2 = alu_op1;
            #1;
            chk($sformatf("alu_rand_f%0d", alu_fun), alu_data, alu_model(alu_op1, alu_op2, alu_fun));
        end

        // Random CSR ops against a register-map model (all start at 0 after reset)
        m_regs = '{default: '0};
        for (int i = 0; i < 120; i++) begin
            int unsigned k = $urandom_range(0, 3);
            logic [1:0]  c = 2'($urandom_range(0, 3));
            logic [31:0] d = $urandom;
            logic [31:0] nv;
            csr_cmd = c; csr_addr = m_addr[k]; csr_wdata = d;
            #1;
            chk("csr_rand_rd", csr_rdata, m_regs[k]);
            chk("csr_rand_ill", {31'b0, csr_illegal}, 32'h0);
            case (c)
                2'd1: nv = d;
                2'd2: nv = m_regs[k] | d;
                2'd3: nv = m_regs[k] & ~d;
                default: nv = m_regs[k];
            endcase
            m_regs[k] = nv & m_mask[k];
            tick();
        end
        csr_cmd = 2'd0;

        // mscratch W/S/C
        csr_op(2'd1, 12'h340, 32'hA5A5_0000); rd(12'h340); chk("mscratch_w", csr_rdata, 32'hA5A5_0000);
        csr_op(2'd2, 12'h340, 32'h0000_00FF); rd(12'h340); chk("mscratch_s", csr_rdata, 32'hA5A5_00FF);
        csr_op(2'd3, 12'h340, 32'hA500_0000); rd(12'h340); chk("mscratch_c", csr_rdata, 32'h00A5_00FF);
        csr_op(2'd1, 12'h305, 32'h0000_1237); rd(12'h305); chk("mtvec_mask", csr_rdata, 32'h1234);
        chk("evec_mtvec", evec, 32'h1234);

        // Unknown address
        csr_cmd = 2'd1; csr_addr = 12'h123; csr_wdata = 32'hFFFF_FFFF; #1;
        chk("unknown_ill", {31'b0, csr_illegal}, 32'h1);
        chk("unknown_rd", csr_rdata, 32'h0);
        csr_cmd = 2'd0;

        // mcycle wrap, then write to read-only alias
        csr_cmd = 2'd1; csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
        tick();
        rd(12'hB00); chk("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
        tick();
        rd(12'hB00); chk("mcycle_wrap", csr_rdata, 32'h0);
        csr_cmd = 2'd1; csr_addr = 12'hC00; csr_wdata = 32'h1234_0000; #1;
        chk("cycle_wr_ill", {31'b0, csr_illegal}, 32'h1);
        tick();
        rd(12'hB00); chk("mcycle_after_ill", csr_rdata, 32'h1);
        csr_cmd = 2'd2; csr_addr = 12'hC02; #1;
        chk("instret_set_ill", {31'b0, csr_illegal}, 32'h1);
        csr_cmd = 2'd0;

        // minstret counts only retire pulses
        csr_op(2'd1, 12'hB02, 32'h0);
        retire = 1'b1; tick(); retire = 1'b0; tick();
        retire = 1'b1; tick(); tick(); retire = 1'b0; tick(); tick();
        rd(12'hB02); chk("minstret_3", csr_rdata, 32'd3);
        rd(12'hC02); chk("instret_alias", csr_rdata, 32'd3);

        // Trap with simultaneous mepc write
        csr_op(2'd1, 12'h300, 32'hFFFF_FFFF); rd(12'h300); chk("mie_set", csr_rdata, 32'h8);
        exception = 1'b1; exc_pc = 32'h8000_0103; exc_cause = 32'h2;
        csr_cmd = 2'd1; csr_addr = 12'h341; csr_wdata = 32'h55;
        tick();
        exception = 1'b0; csr_cmd = 2'd0;
        rd(12'h341); chk("trap_mepc", csr_rdata, 32'h8000_0100);
        rd(12'h342); chk("trap_mcause", csr_rdata, 32'h2);
        rd(12'h300); chk("trap_mie", csr_rdata, 32'h0);
        // Trap alongside a write to an unrelated CSR
        exception = 1'b1; exc_pc = 32'h0000_0ABC; exc_cause = 32'h8000_000B;
        csr_cmd = 2'd1; csr_addr = 12'h340; csr_wdata = 32'h1111_2222;
        tick();
        exception = 1'b0; csr_cmd = 2'd0;
        rd(12'h340); chk("trap_other_wr", csr_rdata, 32'h1111_2222);
        rd(12'h341); chk("trap2_mepc", csr_rdata, 32'h0000_0ABC);
        rd(12'h342); chk("trap2_mcause", csr_rdata, 32'h8000_000B);

        // Breakpoint
        csr_op(2'd1, 12'h7A2, 32'h200);
        csr_op(2'd1, 12'h7A1, 32'hFFFF_FFFF);
        rd(12'h7A1); chk("tdata1_mask", csr_rdata, 32'h1);
        fetch_pc = 32'h200; #1; chk("bp_hit", {31'b0, bp_hit}, 32'h1);
        fetch_pc = 32'h204; #1; chk("bp_miss", {31'b0, bp_hit}, 32'h0);
        fetch_pc = 32'h200;
        csr_op(2'd1, 12'h7A1, 32'h0); chk("bp_disabled", {31'b0, bp_hit}, 32'h0);
        csr_op(2'd2, 12'h7A1, 32'h1); chk("bp_reenabled", {31'b0, bp_hit}, 32'h1);

        // Reset mid-operation beats exception, write and increment
        reset = 1'b1; exception = 1'b1; exc_cause = 32'h7; exc_pc = 32'h44;
        csr_cmd = 2'd1; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF; retire = 1'b1;
        tick();
        reset = 1'b0; exception = 1'b0; retire = 1'b0; csr_cmd = 2'd0;
        chk("rst_bp", {31'b0, bp_hit}, 32'h0);
        chk("rst_evec", evec, 32'h100);
        rd(12'h340); chk("rst_mscratch", csr_rdata, 32'h0);
        rd(12'h342); chk("rst_mcause", csr_rdata, 32'h0);
        rd(12'h341); chk("rst_mepc", csr_rdata, 32'h0);
        rd(12'hB00); chk("rst_mcycle", csr_rdata, 32'h0);
        rd(12'hB02); chk("rst_minstret", csr_rdata, 32'h0);
        rd(12'h7A2); chk("rst_tdata2", csr_rdata, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
